// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM states and the status flag bundle.
package alu_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_INC  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_XOR  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_AND  = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;
    localparam logic [2:0] OP_RSVD = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // c: carry/borrow/mul-overflow, z: zero, n: negative, v: signed overflow, err: reserved opcode
    typedef struct packed {
        logic c;
        logic z;
        logic n;
        logic v;
        logic err;
    } flags_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier, one multiplier bit per cycle.
// The first partial-product step is taken on the start edge itself, so the
// full product is ready WIDTH-1 edges later and done pulses for one cycle.
module alu_mul_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [2*WIDTH-1:0] step_acc_s;
    logic [WIDTH-1:0]   step_mcand_s;
    logic               step_bit_s;
    logic [WIDTH:0]     step_sum_s;
    logic [2*WIDTH-1:0] step_next_s;

    // One shift-add step: add the multiplicand into the upper half if the current bit is set, then shift right.
    always_comb begin
        step_acc_s   = acc_q;
        step_mcand_s = mcand_q;
        step_bit_s   = mplier_q[0];
        if (start) begin
            step_acc_s   = {(2*WIDTH){1'b0}};
            step_mcand_s = a;
            step_bit_s   = b[0];
        end else begin
            step_bit_s   = mplier_q[0];
        end
        step_sum_s  = {1'b0, step_acc_s[2*WIDTH-1:WIDTH]}
                    + (step_bit_s ? {1'b0, step_mcand_s} : {(WIDTH+1){1'b0}});
        step_next_s = {step_sum_s, step_acc_s[WIDTH-1:1]};
    end

    // Iteration control: load on start, step while busy, flag completion after the last bit.
    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        if (start) begin
            acc_d    = step_next_s;
            mcand_d  = a;
            mplier_d = {1'b0, b[WIDTH-1:1]};
            cnt_d    = CW'(1);
            busy_d   = 1'b1;
        end else if (busy_q) begin
            acc_d    = step_next_s;
            mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end else begin
                busy_d = 1'b1;
            end
        end else begin
            busy_d = 1'b0;
        end
    end

    // Multiplier state registers; reset discards any partial product.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= {(2*WIDTH){1'b0}};
            mcand_q  <= {WIDTH{1'b0}};
            mplier_q <= {WIDTH{1'b0}};
            cnt_q    <= {CW{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = acc_q;

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes: six single-cycle ops, an
// iterative unsigned multiply and a reserved opcode that raises err.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_hi,
    output logic             c_out,
    output logic             zero,
    output logic             neg,
    output logic             ovf,
    output logic             err
);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic [WIDTH-1:0]   out_hi_q, out_hi_d;
    flags_t             flags_q, flags_d;

    logic               accept_s;
    logic               mul_start_s;
    logic               mul_busy_s;
    logic               mul_done_s;
    logic [2*WIDTH-1:0] mul_prod_s;
    logic [WIDTH-1:0]   mul_lo_s;
    logic [WIDTH-1:0]   mul_hi_s;
    flags_t             mul_flags_s;

    logic [WIDTH:0]     add_s, inc_s, sub_s;
    logic [WIDTH-1:0]   alu_res_s;
    flags_t             alu_flags_s;

    assign in_ready    = (state_q == ST_IDLE) && !mul_busy_s;
    assign accept_s    = in_valid && in_ready;
    assign mul_start_s = accept_s && (sel == OP_MUL);
    assign mul_lo_s    = mul_prod_s[WIDTH-1:0];
    assign mul_hi_s    = mul_prod_s[2*WIDTH-1:WIDTH];

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start_s),
        .a       (a),
        .b       (b),
        .busy    (mul_busy_s),
        .done    (mul_done_s),
        .product (mul_prod_s)
    );

    // Single-cycle op mux and flags, computed straight from the operands presented at accept.
    always_comb begin
        add_s       = {1'b0, a} + {1'b0, b};
        inc_s       = {1'b0, a} + {{WIDTH{1'b0}}, 1'b1};
        sub_s       = {1'b0, a} - {1'b0, b};
        alu_res_s   = {WIDTH{1'b0}};
        alu_flags_s = '0;
        case (sel)
            OP_ADD: begin
                alu_res_s     = add_s[WIDTH-1:0];
                alu_flags_s.c = add_s[WIDTH];
                alu_flags_s.v = (a[WIDTH-1] == b[WIDTH-1]) && (add_s[WIDTH-1] != a[WIDTH-1]);
            end
            OP_INC: begin
                alu_res_s     = inc_s[WIDTH-1:0];
                alu_flags_s.c = inc_s[WIDTH];
                alu_flags_s.v = !a[WIDTH-1] && inc_s[WIDTH-1];
            end
            OP_SUB: begin
                alu_res_s     = sub_s[WIDTH-1:0];
                alu_flags_s.c = sub_s[WIDTH];
                alu_flags_s.v = (a[WIDTH-1] != b[WIDTH-1]) && (sub_s[WIDTH-1] != a[WIDTH-1]);
            end
            OP_XOR:  alu_res_s = a ^ b;
            OP_OR:   alu_res_s = a | b;
            OP_AND:  alu_res_s = a & b;
            OP_RSVD: alu_flags_s.err = 1'b1;
            default: alu_res_s = {WIDTH{1'b0}};
        endcase
        alu_flags_s.z = (alu_res_s == {WIDTH{1'b0}});
        alu_flags_s.n = alu_res_s[WIDTH-1];
    end

    // Flags for a finished multiply: carry means the product does not fit in WIDTH bits.
    always_comb begin
        mul_flags_s     = '0;
        mul_flags_s.c   = |mul_hi_s;
        mul_flags_s.z   = (mul_prod_s == {(2*WIDTH){1'b0}});
        mul_flags_s.n   = mul_lo_s[WIDTH-1];
        mul_flags_s.v   = 1'b0;
        mul_flags_s.err = 1'b0;
    end

    // Next-state and output-register loading; results are only written on the way into DONE.
    always_comb begin
        state_d  = state_q;
        out_d    = out_q;
        out_hi_d = out_hi_q;
        flags_d  = flags_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s && (sel == OP_MUL)) begin
                    state_d = ST_MUL;
                end else if (accept_s) begin
                    state_d  = ST_DONE;
                    out_d    = alu_res_s;
                    out_hi_d = {WIDTH{1'b0}};
                    flags_d  = alu_flags_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (mul_done_s) begin
                    state_d  = ST_DONE;
                    out_d    = mul_lo_s;
                    out_hi_d = mul_hi_s;
                    flags_d  = mul_flags_s;
                end else begin
                    state_d = ST_MUL;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and result registers; outputs stay frozen while DONE waits for out_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            out_q    <= {WIDTH{1'b0}};
            out_hi_q <= {WIDTH{1'b0}};
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            out_q    <= out_d;
            out_hi_q <= out_hi_d;
            flags_q  <= flags_d;
        end
    end

    assign out_valid = (state_q == ST_DONE);
    assign out       = out_q;
    assign out_hi    = out_hi_q;
    assign c_out     = flags_q.c;
    assign zero      = flags_q.z;
    assign neg       = flags_q.n;
    assign ovf       = flags_q.v;
    assign err       = flags_q.err;

endmodule
